// File: rtl/mx_norm_pkg.sv
// Shared types and default widths for the product normalizer.
package mx_norm_pkg;

  // Rounding mode carried with each beat.
  typedef enum logic {
    RND_TRUNC = 1'b0,
    RND_RNE   = 1'b1
  } rnd_mode_e;

  // Classification decided in stage 1 and resolved in stage 2.
  typedef enum logic [1:0] {
    KindNorm,
    KindZero,
    KindFlush,
    KindOvf
  } beat_kind_e;

  localparam int unsigned DefExpW    = 8;
  localparam int unsigned DefManInW  = 16;
  localparam int unsigned DefManOutW = 7;

endpackage

// File: rtl/mx_lzc.sv
// Leading-zero counter; an all-zero input yields W.
module mx_lzc #(
  parameter int unsigned W = 15,
  localparam int unsigned CntW = $clog2(W + 1)
) (
  input  logic [W-1:0]    data_i,
  output logic [CntW-1:0] cnt_o
);

  // Scan upward so the highest set bit sets the final count.
  always_comb begin
    cnt_o = CntW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (data_i[i]) cnt_o = CntW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/mult_norm_pipe.sv
// Two-stage normalizer/rounder for raw multiplier products.
// Stage 1: carry handling, leading-zero count, shift. Stage 2: rounding,
// exponent adjust, saturation and flush.
module mult_norm_pipe
  import mx_norm_pkg::*;
#(
  parameter int unsigned EXP_W     = DefExpW,
  parameter int unsigned MAN_IN_W  = DefManInW,
  parameter int unsigned MAN_OUT_W = DefManOutW
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W:0]       in_e,
  input  logic [MAN_IN_W-1:0]  in_m,
  input  logic                 in_rnd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W-1:0]     out_e,
  output logic [MAN_OUT_W-1:0] out_m,
  output logic                 out_ovf,
  output logic                 out_unf
);

  // Normalized field below the carry bit; its MSB is the leading-1 slot.
  localparam int unsigned NormW    = MAN_IN_W - 1;
  localparam int unsigned LzW      = $clog2(NormW + 1);
  // Two spare bits so carry and rounding increments never wrap.
  localparam int unsigned ExpIW    = EXP_W + 2;
  localparam int unsigned GuardIdx = NormW - 1 - MAN_OUT_W;

  localparam logic [ExpIW-1:0]     ESat    = {2'b00, {EXP_W{1'b1}}};
  localparam logic [MAN_OUT_W-1:0] MHidden = {1'b1, {(MAN_OUT_W - 1){1'b0}}};

  // Handshake
  logic s1_valid_q;
  logic s1_adv;
  logic s2_adv;
  logic out_valid_q;

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;

  // Stage 1 datapath
  logic [LzW-1:0]       lz;
  logic [NormW-1:0]     norm;
  logic                 shift_out;
  logic [ExpIW-1:0]     in_e_x;
  logic [ExpIW-1:0]     lz_x;

  beat_kind_e           s1_kind_d, s1_kind_q;
  logic [ExpIW-1:0]     s1_e_d, s1_e_q;
  logic [MAN_OUT_W-1:0] s1_m_d, s1_m_q;
  logic                 s1_guard_d, s1_guard_q;
  logic                 s1_sticky_d, s1_sticky_q;
  rnd_mode_e            s1_rnd_q;

  mx_lzc #(
    .W (NormW)
  ) u_lzc (
    .data_i (in_m[NormW-1:0]),
    .cnt_o  (lz)
  );

  assign in_e_x = ExpIW'(in_e);
  assign lz_x   = ExpIW'(lz);

  // Classify the incoming beat and align its mantissa.
  always_comb begin
    s1_kind_d = KindNorm;
    s1_e_d    = '0;
    norm      = '0;
    shift_out = 1'b0;
    if (in_e[EXP_W]) begin
      s1_kind_d = KindOvf;
    end else if (in_m[MAN_IN_W-1]) begin
      norm      = in_m[MAN_IN_W-1:1];
      shift_out = in_m[0];
      s1_e_d    = in_e_x + ExpIW'(1);
    end else if (in_m == '0) begin
      s1_kind_d = KindZero;
    end else if (in_e_x <= lz_x) begin
      s1_kind_d = KindFlush;
    end else begin
      norm   = in_m[NormW-1:0] << lz;
      s1_e_d = in_e_x - lz_x;
    end
    s1_m_d      = norm[NormW-1 -: MAN_OUT_W];
    s1_guard_d  = norm[GuardIdx];
    s1_sticky_d = (|norm[GuardIdx-1:0]) | shift_out;
  end

  // Stage 1 register: load a new beat (or a bubble) whenever it can move on.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_kind_q   <= KindZero;
      s1_e_q      <= '0;
      s1_m_q      <= '0;
      s1_guard_q  <= 1'b0;
      s1_sticky_q <= 1'b0;
      s1_rnd_q    <= RND_TRUNC;
    end else if (s1_adv) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_kind_q   <= s1_kind_d;
        s1_e_q      <= s1_e_d;
        s1_m_q      <= s1_m_d;
        s1_guard_q  <= s1_guard_d;
        s1_sticky_q <= s1_sticky_d;
        s1_rnd_q    <= rnd_mode_e'(in_rnd);
      end
    end
  end

  // Stage 2 datapath
  logic                 inc;
  logic [MAN_OUT_W:0]   m_sum;
  logic [MAN_OUT_W-1:0] m_r;
  logic [ExpIW-1:0]     e_r;
  logic [EXP_W-1:0]     out_e_d, out_e_q;
  logic [MAN_OUT_W-1:0] out_m_d, out_m_q;
  logic                 out_ovf_d, out_ovf_q;
  logic                 out_unf_d, out_unf_q;

  // Round, renormalize on carry-out, then saturate or pass through.
  always_comb begin
    inc   = (s1_rnd_q == RND_RNE) && s1_guard_q && (s1_sticky_q || s1_m_q[0]);
    m_sum = {1'b0, s1_m_q} + {{MAN_OUT_W{1'b0}}, inc};
    if (m_sum[MAN_OUT_W]) begin
      m_r = MHidden;
      e_r = s1_e_q + ExpIW'(1);
    end else begin
      m_r = m_sum[MAN_OUT_W-1:0];
      e_r = s1_e_q;
    end

    out_e_d   = '0;
    out_m_d   = '0;
    out_ovf_d = 1'b0;
    out_unf_d = 1'b0;
    unique case (s1_kind_q)
      KindOvf: begin
        out_e_d   = '1;
        out_ovf_d = 1'b1;
      end
      KindZero: ;
      KindFlush: out_unf_d = 1'b1;
      KindNorm: begin
        if (e_r >= ESat) begin
          out_e_d   = '1;
          out_ovf_d = 1'b1;
        end else begin
          out_e_d = e_r[EXP_W-1:0];
          out_m_d = m_r;
        end
      end
      default: ;
    endcase
  end

  // Output register: holds data steady while downstream stalls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_e_q     <= '0;
      out_m_q     <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
    end else if (s2_adv) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_e_q   <= out_e_d;
        out_m_q   <= out_m_d;
        out_ovf_q <= out_ovf_d;
        out_unf_q <= out_unf_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_e     = out_e_q;
  assign out_m     = out_m_q;
  assign out_ovf   = out_ovf_q;
  assign out_unf   = out_unf_q;

endmodule

// File: tb/tb_mult_norm_pipe.sv
// Self-checking bench for mult_norm_pipe at default widths.
module tb_mult_norm_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [8:0] in_e;
  logic [15:0] in_m;
  logic       in_rnd;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_e;
  logic [6:0] out_m;
  logic       out_ovf;
  logic       out_unf;
  logic [16:0] dut_out;

  always #5 clk = ~clk;

  mult_norm_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_e      (in_e),
    .in_m      (in_m),
    .in_rnd    (in_rnd),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_e     (out_e),
    .out_m     (out_m),
    .out_ovf   (out_ovf),
    .out_unf   (out_unf)
  );

  assign dut_out = {out_e, out_m, out_ovf, out_unf};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, want);
    end
  endtask

  function automatic logic [16:0] pk(input int e, input int m, input bit o, input bit u);
    logic [7:0] ev;
    logic [6:0] mv;
    ev = 8'(e);
    mv = 7'(m);
    return {ev, mv, o, u};
  endfunction

  // Reference: value-level normalize/round from the position of the top set bit.
  function automatic logic [16:0] model(input int e, input int m, input bit rnd);
    int p, ev, mant, sh;
    bit guard, sticky;
    if (e >= 256) return pk(255, 0, 1, 0);
    if (m == 0) return pk(0, 0, 0, 0);
    p = 15;
    while (((m >> p) & 1) == 0) p--;
    if (p <= 14 && e <= 14 - p) return pk(0, 0, 0, 1);
    ev = e + p - 14;
    sh = p - 6;
    if (sh > 0) begin
      mant   = m >> sh;
      guard  = ((m >> (sh - 1)) & 1) != 0;
      sticky = (m & ((1 << (sh - 1)) - 1)) != 0;
    end else begin
      mant   = m << (-sh);
      guard  = 1'b0;
      sticky = 1'b0;
    end
    if (rnd && guard && (sticky || (mant & 1) != 0)) mant++;
    if (mant == 128) begin
      mant = 64;
      ev++;
    end
    if (ev >= 255) return pk(255, 0, 1, 0);
    return pk(ev, mant, 0, 0);
  endfunction

  // Scoreboard and per-cycle output checks.
  logic [16:0] exp_q[$];
  logic [16:0] prev_out;
  bit          prev_stall = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", 32'(out_valid), 32'd1);
        check("hold_data", 32'(dut_out), 32'(prev_out));
      end
      if (out_valid) check("flags_excl", 32'(out_ovf & out_unf), 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_beat: got %0h, expected no beat", dut_out);
        end else begin
          check("result", 32'(dut_out), 32'(exp_q.pop_front()));
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(int'(in_e), int'(in_m), in_rnd));
      prev_stall = out_valid && !out_ready;
      prev_out   = dut_out;
    end
  end

  // Present one beat and hold it until accepted; returns at posedge+1.
  task automatic send(input int e, input int m, input bit r);
    bit fired;
    in_valid = 1'b1;
    in_e     = 9'(e);
    in_m     = 16'(m);
    in_rnd   = r;
    fired    = 1'b0;
    for (int k = 0; k < 200 && !fired; k++) begin
      @(negedge clk);
      fired = in_ready;
      @(posedge clk);
      #1;
    end
    if (!fired) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: got in_ready stuck low, expected acceptance");
    end
    in_valid = 1'b0;
  endtask

  // One beat through an empty pipe: latency and literal result.
  task automatic directed(input string nm, input int e, input int m, input bit r,
                          input logic [16:0] want);
    check({nm, "_model"}, 32'(model(e, m, r)), 32'(want));
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_e      = 9'(e);
    in_m      = 16'(m);
    in_rnd    = r;
    @(negedge clk);
    check({nm, "_rdy"}, 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({nm, "_lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({nm, "_lat2"}, 32'(out_valid), 32'd1);
    check({nm, "_out"}, 32'(dut_out), 32'(want));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected completion");
    $fatal(1);
  end

  initial begin
    bit done;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_e      = '0;
    in_m      = '0;
    in_rnd    = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(dut_out), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    directed("basic", 100, 16'h0200, 1'b0, pk(95, 7'h40, 0, 0));
    directed("carry", 10, 16'hC000, 1'b0, pk(11, 7'h60, 0, 0));
    directed("ovf_in", 300, 16'hC000, 1'b0, pk(255, 0, 1, 0));
    directed("rne_up", 50, 16'h7F80, 1'b1, pk(51, 7'h40, 0, 0));
    directed("trunc", 50, 16'h7F80, 1'b0, pk(50, 7'h7F, 0, 0));
    directed("flush", 3, 16'h0010, 1'b0, pk(0, 0, 0, 1));
    directed("zero", 3, 0, 1'b1, pk(0, 0, 0, 0));
    directed("sat_rnd", 254, 16'h7F80, 1'b1, pk(255, 0, 1, 0));
    directed("sat_cry", 254, 16'h8000, 1'b0, pk(255, 0, 1, 0));
    directed("rne_tie", 20, 16'h4080, 1'b1, pk(20, 7'h40, 0, 0));

    // Four back-to-back beats against a three-cycle downstream stall.
    fork
      begin
        send(40, 16'h1234, 1'b1);
        send(41, 16'h8001, 1'b0);
        send(42, 16'h00FF, 1'b1);
        send(43, 16'h7FFF, 1'b1);
      end
      begin
        out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        check("stall_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Reset while stalled drops everything in flight.
    out_ready = 1'b0;
    send(60, 16'h0F0F, 1'b0);
    send(61, 16'hF0F0, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_valid", 32'(out_valid), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("no_stale", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random backpressure.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          int e, m;
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          case ($urandom_range(0, 9))
            0:       e = $urandom_range(256, 511);
            1, 2:    e = $urandom_range(245, 255);
            3:       e = $urandom_range(0, 15);
            default: e = $urandom_range(0, 255);
          endcase
          m = $urandom_range(0, 65535) >> $urandom_range(0, 16);
          send(e, m, 1'($urandom_range(0, 1)));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(posedge clk);
    @(negedge clk);
    check("drain", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_norm_pipe.md
MULT_NORM_PIPE -- requirements
Module: mult_norm_pipe

Interface
REQ-001 Parameter EXP_W, default 8: output exponent width; input exponent is EXP_W+1 bits, with the MSB used as the overflow flag.
REQ-002 Parameter MAN_IN_W, default 16: raw product mantissa width; bit MAN_IN_W-1 is carry, bit MAN_IN_W-2 is the normalized leading-1 position.
REQ-003 Parameter MAN_OUT_W, default 7: output mantissa width, leading 1 included; must satisfy MAN_OUT_W+2 <= MAN_IN_W-1.
REQ-004 clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 in_valid  input  1  input beat valid.
REQ-007 in_ready  output  1  block accepts a beat when in_valid & in_ready.
REQ-008 in_e  input  EXP_W+1  unnormalized biased exponent.
REQ-009 in_m  input  MAN_IN_W  unnormalized product mantissa.
REQ-010 in_rnd  input  1  rounding mode, sampled with the beat: 0 = truncate, 1 = round-to-nearest-even (RNE).
REQ-011 out_valid  output  1  result valid.
REQ-012 out_ready  input  1  downstream accepts when out_valid & out_ready.
REQ-013 out_e  output  EXP_W  normalized exponent.
REQ-014 out_m  output  MAN_OUT_W  normalized mantissa.
REQ-015 out_ovf  output  1  result saturated.
REQ-016 out_unf  output  1  result flushed to zero.

Function
REQ-017 The block SHALL be a 2-stage pipeline: S1 performs carry handling, leading-zero count and shift; S2 performs rounding, exponent adjust and saturation/flush.
REQ-018 Latency from acceptance to out_valid SHALL be exactly 2 cycles with no stall; throughput SHALL be 1 beat/cycle.
REQ-019 A stage SHALL advance when it is empty or its successor advances; in_ready = !S1_valid | S1_advance; S2 holds while out_valid & !out_ready.
REQ-020 Output data and flags SHALL remain stable while out_valid & !out_ready; beats SHALL leave in order with none lost or duplicated.
REQ-021 If in_e[EXP_W]=1: out_e = all-ones, out_m = 0, out_ovf = 1.
REQ-022 Else if in_m[MAN_IN_W-1]=1: shift right 1, exponent +1, and OR the shifted-out bit into sticky.
REQ-023 Else if in_m = 0: out_e = 0, out_m = 0, out_ovf = 0, out_unf = 0.
REQ-024 Else: let lz = leading zeros of in_m[MAN_IN_W-2:0]; if in_e <= lz, flush (out_e = 0, out_m = 0, out_unf = 1); otherwise shift left by lz and set exponent = in_e - lz.
REQ-025 out_m SHALL be normalized bits [MAN_IN_W-2 -: MAN_OUT_W]; guard = next lower bit; sticky = OR of all remaining lower bits.
REQ-026 RNE: increment when guard & (sticky | lsb); truncate mode never increments.
REQ-027 On rounding carry-out: out_m = 1 << (MAN_OUT_W-1) and exponent +1.
REQ-028 A final exponent >= 2^EXP_W-1 SHALL saturate: out_e = all-ones, out_m = 0, out_ovf = 1.
REQ-029 out_ovf and out_unf SHALL never both be 1.

Reset
REQ-030 While rst_n=0 at a clock edge: S1/S2 valid = 0, out_valid = 0, out_e/out_m/flags = 0.
REQ-031 in_ready SHALL read 1 in the first cycle after reset release.
REQ-032 Reset mid-stall SHALL discard all in-flight beats.

Structure
REQ-033 Package mx_norm_pkg SHALL hold the rounding-mode enum (RND_TRUNC, RND_RNE) and default width constants.
REQ-034 Sub-module mx_lzc (parametrised leading-zero counter, width W, output $clog2(W+1) bits) SHALL be instantiated in S1.

Verification (default parameters)
REQ-035 in_e=100, in_m=16'h0200, trunc -> after 2 cycles out_e=95, out_m=7'h40, flags 0.
REQ-036 in_e=10, in_m=16'hC000 -> out_e=11, out_m=7'h60; in_e=9'd300 -> out_e=255, out_m=0, out_ovf=1.
REQ-037 in_e=50, in_m=16'h7F80: RNE -> out_e=51, out_m=7'h40; trunc -> out_e=50, out_m=7'h7F.
REQ-038 in_e=3, in_m=16'h0010 (lz=10) -> out_e=0, out_m=0, out_unf=1; in_m=0 -> all zero, no flags.
REQ-039 4 back-to-back beats with out_ready=0 for 3 cycles -> in_ready drops after 2 accepted, outputs stay stable, all 4 delivered in order.
REQ-040 rst_n=0 during a stall -> out_valid=0 and in_ready=1 on the next cycle, and no stale beat appears.
